uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered 8N1 UART transmitter driving uart_txd, the outbound counterpart to
//   the UART receive path in the PWM sine design. Accepts bytes via valid/ready,
//   queues them in a small FIFO and serialises them LSB-first.
//   Returns status and readback bytes (e.g. sine settings) to the host.
// PARAMETERS
//   CLKS_PER_BIT  87  clk cycles per UART bit (10 MHz / 115200 baud); legal >= 4
//   FIFO_DEPTH    8   byte FIFO entries; power of 2, >= 2
// PORTS
//   clk        in   1                      system clock, all logic on rising edge
//   rst_n      in   1                      reset, synchronous, active-low
//   tx_data    in   8                      byte to transmit
//   tx_valid   in   1                      tx_data valid this cycle
//   tx_ready   out  1                      FIFO can accept; write = tx_valid & tx_ready
//   uart_txd   out  1                      serial line, idle high
//   tx_busy    out  1                      frame in progress or FIFO non-empty
//   fifo_count out  $clog2(FIFO_DEPTH)+1   bytes queued, excluding frame in flight
// BEHAVIOUR
//   Reset, rst_n low at a clock edge: FIFO emptied, FSM -> IDLE, bit counter and
//     baud counter cleared. uart_txd=1, tx_ready=1, tx_busy=0, fifo_count=0.
//     Asserting reset mid-frame aborts the frame; uart_txd is high after that edge.
//   tx_ready = (fifo_count != FIFO_DEPTH). Registered count only; a push is refused
//     when full even if a pop happens in the same cycle.
//   Write and pop in the same cycle: both take effect; fifo_count is unchanged.
//   Write when full (tx_valid=1, tx_ready=0): data dropped, no state change.
//   FSM states: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//     IDLE : txd=1. If FIFO non-empty: pop head into shift reg, go to START.
//     START: txd=0 for CLKS_PER_BIT cycles.
//     DATA : txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right.
//            8 bits sent, bit index 0..7, LSB first.
//     STOP : txd=1 for CLKS_PER_BIT cycles. At end, if FIFO non-empty, pop and
//            go directly to START (back-to-back frames, no idle gap); else IDLE.
//   Latency: write accepted at edge N into an empty FIFO with FSM in IDLE:
//     fifo_count=1 after edge N; pop at edge N+1 sets txd=0 and fifo_count=0.
//   Baud counter runs 0..CLKS_PER_BIT-1. It wraps to 0 on each bit boundary and
//     is reloaded at START entry, so every bit is exactly CLKS_PER_BIT cycles.
//   Frame length = 10*CLKS_PER_BIT cycles (11* with parity).
//   FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//     fifo_count is one bit wider so that full is distinguishable.
//   tx_busy = (state != IDLE) | (fifo_count != 0); registered with the FSM.
//   All outputs are registered or derived from registers only; no comb path from
//     tx_valid.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: state PARITY inserted between DATA and STOP.
//     txd = ^byte (even parity) for CLKS_PER_BIT cycles. Frame is 8E1, 11 bits.
//   UART_TX_PARITY_EN undefined: no PARITY state. Frame is 8N1, 10 bits.
// TESTING
//   1 Reset release, no writes for 1000 cycles -> txd=1, tx_ready=1, tx_busy=0,
//     fifo_count=0.
//   2 Write 0xA5 when idle, CLKS_PER_BIT=4 -> txd low 1 cycle after accept edge.
//     Line pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
//   3 Burst-write 0x00..0x08 (9 bytes), DEPTH=8 -> first byte popped, the rest
//     fill the FIFO. No byte lost; if a write meets a full FIFO, tx_ready=0 holds
//     that byte until space frees. Frames go back-to-back with no idle.
//   4 Write on the same edge as an end-of-STOP pop, count=3 -> count stays 3.
//     Next frame starts immediately.
//   5 rst_n low during DATA bit 4 of 0xFF, 3 bytes queued -> after that edge
//     txd=1, fifo_count=0, tx_busy=0. A new write 0x3C transmits correctly.
//   6 With UART_TX_PARITY_EN, send 0x07 -> parity bit=1, 11-bit frame.
//     Send 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter. Bytes are accepted over a valid/ready handshake,
//   queued in a small FIFO and serialised LSB-first on uart_txd (idle high).
//   Default frame is 8N1; defining UART_TX_PARITY_EN inserts an even-parity bit
//   (8E1, 11 bits per frame).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   tx_data     byte to queue
//   tx_valid    tx_data valid; write happens on tx_valid & tx_ready
//   tx_ready    FIFO not full (registered count only)
//   uart_txd    serial output, idle high
//   tx_busy     frame in progress or bytes queued
//   fifo_count  bytes queued, excluding the frame in flight
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic [7:0]      shift, shift_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [BW-1:0]   baud, baud_n;
    logic            txd_r, txd_n;
    logic            busy_r, busy_n;
    logic            push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    // Full test uses the registered count only, so a same-cycle pop never
    // frees space for a push.
    assign push    = tx_valid && (count != CW'(FIFO_DEPTH));
    assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        baud_n    = bit_end ? '0 : baud + BW'(1);
        txd_n     = txd_r;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                txd_n  = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    state_n = START;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    txd_n     = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = shift >> 1;
                        txd_n     = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Back-to-back: pop straight into START with no idle bit.
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_n   = ^mem[rd_ptr];
`endif
                        state_n = START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
        count_n = count + CW'(push) - CW'(pop);
        busy_n  = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            count   <= count_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            baud    <= baud_n;
            txd_r   <= txd_n;
            busy_r  <= busy_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= tx_data;
    end

    assign tx_ready   = (count != CW'(FIFO_DEPTH));
    assign uart_txd   = txd_r;
    assign tx_busy    = busy_r;
    assign fifo_count = count;

endmodule
